// File: rtl/fetch_control_unit.sv
// Fetch address generator: resolves decoder redirects, keeps a circular call/return
// stack, and holds the fetch address across hazard and program-cache-miss stalls.
module fetch_control_unit #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter int unsigned           STACK_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  p_cache_miss,
  input  logic                  pc_jmp,
  input  logic                  pc_brx,
  input  logic                  pc_brxt,
  input  logic                  pc_call,
  input  logic                  pc_ret,
  input  logic [1:0]            cond_sel,
  input  logic                  flag_n,
  input  logic                  flag_z,
  input  logic                  flag_p,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  output logic [ADDR_WIDTH-1:0] prg_addr,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  logic                  stall;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] stack_top;
  logic                  cond_flag;
  logic                  br_taken;
  logic                  red_valid;
  logic [ADDR_WIDTH-1:0] red_target;
  logic                  do_push;
  logic                  do_pop;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_target;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  pend_valid_nxt;
  logic [ADDR_WIDTH-1:0] pend_target_nxt;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]      sp;
  logic [PTR_W-1:0]      sp_nxt;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  err_nxt;

  always_comb begin
    stall     = hazard | p_cache_miss;
    // The decoder repeats its strobes during a hazard; sample them only when it is low.
    accept    = ~hazard;
    addr_inc  = prg_addr + ADDR_WIDTH'(1);
    stack_top = stack_mem[sp - PTR_W'(1)];
  end

  always_comb begin
    cond_flag = 1'b0;
    case (cond_sel)
      2'b01:   cond_flag = flag_n;
      2'b10:   cond_flag = flag_z;
      2'b11:   cond_flag = flag_p;
      default: cond_flag = 1'b0;
    endcase
    br_taken = (cond_sel == 2'b00) ? 1'b1 : (cond_flag ^ pc_brxt);
  end

  // Priority call > ret > jmp > brx; stack side effects happen here, at acceptance.
  always_comb begin
    red_valid  = 1'b0;
    red_target = target_addr;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    if (accept) begin
      if (pc_call) begin
        red_valid = 1'b1;
        do_push   = 1'b1;
      end else if (pc_ret) begin
        red_valid  = 1'b1;
        red_target = stack_top;
        do_pop     = 1'b1;
      end else if (pc_jmp) begin
        red_valid = 1'b1;
      end else if (pc_brx) begin
        red_valid = br_taken;
      end
    end
  end

  always_comb begin
    addr_nxt        = prg_addr;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (!stall) begin
      if (red_valid) begin
        addr_nxt = red_target;
      end else if (pend_valid) begin
        addr_nxt = pend_target;
      end else begin
        addr_nxt = addr_inc;
      end
      pend_valid_nxt = 1'b0;
    end else if (red_valid) begin
      pend_valid_nxt  = 1'b1;
      pend_target_nxt = red_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prg_addr    <= RESET_ADDR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      prg_addr    <= addr_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  // Full pushes and empty pops still move the pointer, so the buffer wraps circularly.
  always_comb begin
    sp_nxt    = sp;
    count_nxt = count;
    err_nxt   = stack_err;
    if (do_push) begin
      sp_nxt = sp + PTR_W'(1);
      if (count == CNT_FULL) begin
        err_nxt = 1'b1;
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end else if (do_pop) begin
      sp_nxt = sp - PTR_W'(1);
      if (count == '0) begin
        err_nxt = 1'b1;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp          <= '0;
      count       <= '0;
      stack_empty <= 1'b1;
      stack_full  <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      sp          <= sp_nxt;
      count       <= count_nxt;
      stack_empty <= (count_nxt == '0);
      stack_full  <= (count_nxt == CNT_FULL);
      stack_err   <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      stack_mem[sp] <= addr_inc;
    end
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: vector table, hand-written stall/stack/reset sequences,
// and randomized traffic against a behavioural model.
module tb_fetch_control_unit;

  localparam int AW = 16;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst, hazard, p_cache_miss;
  logic          pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret;
  logic [1:0]    cond_sel;
  logic          flag_n, flag_z, flag_p;
  logic [AW-1:0] target_addr;
  logic [AW-1:0] prg_addr;
  logic          stack_empty, stack_full, stack_err;

  int tests = 0;
  int fails = 0;

  fetch_control_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(D), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .p_cache_miss(p_cache_miss),
    .pc_jmp(pc_jmp), .pc_brx(pc_brx), .pc_brxt(pc_brxt), .pc_call(pc_call),
    .pc_ret(pc_ret), .cond_sel(cond_sel), .flag_n(flag_n), .flag_z(flag_z),
    .flag_p(flag_p), .target_addr(target_addr), .prg_addr(prg_addr),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  // ctl = {hazard, miss, call, ret, jmp, brx, brxt}; npz = {n,z,p}; efl = {empty,full,err}
  typedef struct {
    logic [6:0]  ctl;
    logic [1:0]  cs;
    logic [2:0]  npz;
    logic [15:0] tgt;
    logic [15:0] ea;
    logic [2:0]  efl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    hazard = 1'b0; p_cache_miss = 1'b0; pc_jmp = 1'b0; pc_brx = 1'b0; pc_brxt = 1'b0;
    pc_call = 1'b0; pc_ret = 1'b0; cond_sel = 2'b00; flag_n = 1'b0; flag_z = 1'b0;
    flag_p = 1'b0; target_addr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic e, input logic f, input logic r);
    chk({name, ".empty"}, {31'd0, stack_empty}, {31'd0, e});
    chk({name, ".full"},  {31'd0, stack_full},  {31'd0, f});
    chk({name, ".err"},   {31'd0, stack_err},   {31'd0, r});
  endtask

  // Behavioural model state
  logic [AW-1:0] m_pc, m_pt;
  bit            m_pv, m_err;
  logic [AW-1:0] m_mem [D];
  int            m_level, m_entries;

  function automatic int posmod(input int v);
    return ((v % D) + D) % D;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_pv = 0; m_pt = '0; m_err = 0; m_level = 0; m_entries = 0;
  endtask

  task automatic model_step();
    bit            rv;
    logic [AW-1:0] rt;
    bit            flag;
    rv = 0;
    rt = target_addr;
    if (!hazard) begin
      if (pc_call) begin
        rv = 1;
        m_mem[posmod(m_level)] = m_pc + 16'd1;
        m_level++;
        if (m_entries == D) m_err = 1; else m_entries++;
      end else if (pc_ret) begin
        rv = 1;
        m_level--;
        rt = m_mem[posmod(m_level)];
        if (m_entries == 0) m_err = 1; else m_entries--;
      end else if (pc_jmp) begin
        rv = 1;
      end else if (pc_brx) begin
        flag = (cond_sel == 2'd1) ? flag_n : (cond_sel == 2'd2) ? flag_z : flag_p;
        rv = (cond_sel == 2'd0) ? 1'b1 : (flag ^ pc_brxt);
      end
    end
    if (!(hazard || p_cache_miss)) begin
      m_pc = rv ? rt : (m_pv ? m_pt : m_pc + 16'd1);
      m_pv = 0;
    end else if (rv) begin
      m_pv = 1;
      m_pt = rt;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
    chk("reset.addr", {16'd0, prg_addr}, 32'h0);
    chk_flags("reset", 1'b1, 1'b0, 1'b0);

    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0001, 3'b100});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0002, 3'b100});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0003, 3'b100});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0004, 3'b100});
    tbl.push_back('{7'b0000100, 2'b00, 3'b000, 16'h0010, 16'h0010, 3'b100});
    tbl.push_back('{7'b0010000, 2'b00, 3'b000, 16'h0200, 16'h0200, 3'b000});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0201, 3'b000});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0202, 3'b000});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0203, 3'b000});
    tbl.push_back('{7'b0001000, 2'b00, 3'b000, 16'h0000, 16'h0011, 3'b100});
    tbl.push_back('{7'b0000010, 2'b10, 3'b000, 16'h0300, 16'h0012, 3'b100});
    tbl.push_back('{7'b0000011, 2'b10, 3'b000, 16'h0300, 16'h0300, 3'b100});
    tbl.push_back('{7'b0000010, 2'b00, 3'b000, 16'h0350, 16'h0350, 3'b100});
    tbl.push_back('{7'b0000010, 2'b01, 3'b100, 16'h0360, 16'h0360, 3'b100});
    tbl.push_back('{7'b0000010, 2'b11, 3'b000, 16'h0370, 16'h0361, 3'b100});
    tbl.push_back('{7'b0000011, 2'b11, 3'b001, 16'h0370, 16'h0362, 3'b100});
    tbl.push_back('{7'b0010100, 2'b00, 3'b000, 16'h0500, 16'h0500, 3'b000});
    tbl.push_back('{7'b0001110, 2'b00, 3'b000, 16'h0600, 16'h0363, 3'b100});
    tbl.push_back('{7'b0000100, 2'b00, 3'b000, 16'hFFFF, 16'hFFFF, 3'b100});
    tbl.push_back('{7'b0000000, 2'b00, 3'b000, 16'h0000, 16'h0000, 3'b100});
    tbl.push_back('{7'b0000010, 2'b10, 3'b010, 16'h0ABC, 16'h0ABC, 3'b100});

    foreach (tbl[i]) begin
      {hazard, p_cache_miss, pc_call, pc_ret, pc_jmp, pc_brx, pc_brxt} = tbl[i].ctl;
      cond_sel = tbl[i].cs;
      {flag_n, flag_z, flag_p} = tbl[i].npz;
      target_addr = tbl[i].tgt;
      cyc();
      chk($sformatf("vec%0d.addr", i), {16'd0, prg_addr}, {16'd0, tbl[i].ea});
      chk($sformatf("vec%0d.flags", i), {29'd0, stack_empty, stack_full, stack_err},
          {29'd0, tbl[i].efl});
    end
    idle();

    // Jump accepted under a 3-cycle miss, applied when the miss clears
    pc_jmp = 1'b1; target_addr = 16'h0400; p_cache_miss = 1'b1;
    cyc(); chk("miss.hold1", {16'd0, prg_addr}, 32'h0ABC);
    pc_jmp = 1'b0; target_addr = '0;
    cyc(); chk("miss.hold2", {16'd0, prg_addr}, 32'h0ABC);
    cyc(); chk("miss.hold3", {16'd0, prg_addr}, 32'h0ABC);
    p_cache_miss = 1'b0;
    cyc(); chk("miss.apply", {16'd0, prg_addr}, 32'h0400);

    // Call held through a hazard acts exactly once
    hazard = 1'b1; pc_call = 1'b1; target_addr = 16'h0700;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("hz.hold%0d", i), {16'd0, prg_addr}, 32'h0400);
      chk($sformatf("hz.empty%0d", i), {31'd0, stack_empty}, 32'd1);
    end
    hazard = 1'b0;
    cyc(); chk("hz.call", {16'd0, prg_addr}, 32'h0700);
    chk("hz.pushed", {31'd0, stack_empty}, 32'd0);
    idle();
    cyc(); chk("hz.inc", {16'd0, prg_addr}, 32'h0701);
    pc_ret = 1'b1;
    cyc(); chk("hz.ret", {16'd0, prg_addr}, 32'h0401);
    chk_flags("hz.one_push", 1'b1, 1'b0, 1'b0);
    idle();

    // Newer redirect overwrites a pending one
    p_cache_miss = 1'b1; pc_jmp = 1'b1; target_addr = 16'h0800;
    cyc(); chk("pend.hold1", {16'd0, prg_addr}, 32'h0401);
    target_addr = 16'h0900;
    cyc(); chk("pend.hold2", {16'd0, prg_addr}, 32'h0401);
    idle();
    cyc(); chk("pend.newest", {16'd0, prg_addr}, 32'h0900);
    hazard = 1'b1; p_cache_miss = 1'b1; pc_jmp = 1'b1; target_addr = 16'h0A00;
    cyc(); chk("hzmiss.hold", {16'd0, prg_addr}, 32'h0900);
    idle();
    cyc(); chk("hzmiss.ignored", {16'd0, prg_addr}, 32'h0901);

    // Overflow on the 17th call
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      pc_call = 1'b1; target_addr = 16'h0100 + 16'(i);
      cyc();
      chk_flags($sformatf("ovf%0d", i), 1'b0, i >= 16, i == 17);
    end
    idle();

    // Underflow on a ret right after reset
    do_reset();
    pc_ret = 1'b1;
    cyc();
    chk_flags("udf", 1'b1, 1'b0, 1'b1);
    idle();
    cyc();
    chk("udf.sticky", {31'd0, stack_err}, 32'd1);

    // Reset during a pending redirect with three stack entries
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc_call = 1'b1; target_addr = 16'h0200 + 16'(i);
      cyc();
    end
    pc_call = 1'b0; pc_jmp = 1'b1; p_cache_miss = 1'b1; target_addr = 16'h0777;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst6.addr", {16'd0, prg_addr}, 32'h0);
    chk_flags("rst6", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    cyc();
    chk("rst6.discard", {16'd0, prg_addr}, 32'h1);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      hazard       = ($urandom_range(0, 4) == 0);
      p_cache_miss = ($urandom_range(0, 4) == 0);
      pc_call      = ($urandom_range(0, 6) == 0);
      pc_ret       = (m_entries > 0) && ($urandom_range(0, 5) == 0);
      pc_jmp       = ($urandom_range(0, 6) == 0);
      pc_brx       = ($urandom_range(0, 3) == 0);
      pc_brxt      = 1'($urandom_range(0, 1));
      cond_sel     = 2'($urandom_range(0, 3));
      {flag_n, flag_z, flag_p} = 3'($urandom_range(0, 7));
      target_addr  = 16'($urandom);
      model_step();
      cyc();
      chk("rnd.addr", {16'd0, prg_addr}, {16'd0, m_pc});
      chk_flags("rnd", m_entries == 0, m_entries == D, m_err);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
